// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass muxes, load-use hazard detection
// and a saturating count of the bubbles inserted for load-use hazards.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              idValid,
    input  logic [DATA_W-1:0] idRsData,
    input  logic [DATA_W-1:0] idRtData,
    input  logic [DATA_W-1:0] idImm,
    input  logic [4:0]        idRs,
    input  logic [4:0]        idRt,
    input  logic [4:0]        idRd,
    input  logic [1:0]        idAluCtrl,
    input  logic              idAluSrcImm,
    input  logic              idRegWrite,
    input  logic              idMemRead,
    input  logic              idMemWrite,
    input  logic              memFwdEn,
    input  logic [4:0]        memFwdReg,
    input  logic [DATA_W-1:0] memFwdData,
    input  logic              wbFwdEn,
    input  logic [4:0]        wbFwdReg,
    input  logic [DATA_W-1:0] wbFwdData,
    output logic [DATA_W-1:0] aluSrcA,
    output logic [DATA_W-1:0] aluSrcB,
    output logic [1:0]        ctrl,
    output logic              exValid,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic [4:0]        exRd,
    output logic [DATA_W-1:0] exStoreData,
    output logic              loadUseHazard,
    output logic [CNT_W-1:0]  bubbleCount
);

    logic [DATA_W-1:0] exRsData;
    logic [DATA_W-1:0] exRtData;
    logic [DATA_W-1:0] exImm;
    logic [4:0]        exRs;
    logic [4:0]        exRt;
    logic [1:0]        exAluCtrl;
    logic              exAluSrcImm;
    logic [DATA_W-1:0] fwdA;
    logic [DATA_W-1:0] fwdB;

    // A load in EX whose destination is read by the instruction in ID must wait a cycle.
    assign loadUseHazard = exValid & exMemRead & (exRd != 5'd0) & idValid &
                           ((idRs == exRd) | (idRt == exRd));

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid     <= 1'b0;
            exRsData    <= '0;
            exRtData    <= '0;
            exImm       <= '0;
            exRs        <= 5'd0;
            exRt        <= 5'd0;
            exRd        <= 5'd0;
            exAluCtrl   <= 2'd0;
            exAluSrcImm <= 1'b0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            exMemWrite  <= 1'b0;
            bubbleCount <= '0;
        end else if (flush) begin
            exValid    <= 1'b0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
        end else if (!stall) begin
            if (loadUseHazard) begin
                // Data fields are left as they are; only the bubble's control is cleared.
                exValid    <= 1'b0;
                exRegWrite <= 1'b0;
                exMemRead  <= 1'b0;
                exMemWrite <= 1'b0;
                if (bubbleCount != {CNT_W{1'b1}})
                    bubbleCount <= bubbleCount + CNT_W'(1);
            end else begin
                exValid     <= idValid;
                exRsData    <= idRsData;
                exRtData    <= idRtData;
                exImm       <= idImm;
                exRs        <= idRs;
                exRt        <= idRt;
                exRd        <= idRd;
                exAluCtrl   <= idAluCtrl;
                exAluSrcImm <= idAluSrcImm;
                exRegWrite  <= idRegWrite & idValid;
                exMemRead   <= idMemRead & idValid;
                exMemWrite  <= idMemWrite & idValid;
            end
        end
    end

    // The younger result (EX/MEM) wins over MEM/WB; register 0 is never bypassed.
    always_comb begin
        fwdA = exRsData;
        if (memFwdEn && (memFwdReg == exRs) && (exRs != 5'd0))
            fwdA = memFwdData;
        else if (wbFwdEn && (wbFwdReg == exRs) && (exRs != 5'd0))
            fwdA = wbFwdData;
    end

    always_comb begin
        fwdB = exRtData;
        if (memFwdEn && (memFwdReg == exRt) && (exRt != 5'd0))
            fwdB = memFwdData;
        else if (wbFwdEn && (wbFwdReg == exRt) && (exRt != 5'd0))
            fwdB = wbFwdData;
    end

    assign aluSrcA     = fwdA;
    assign aluSrcB     = exAluSrcImm ? exImm : fwdB;
    assign exStoreData = fwdB;
    assign ctrl        = exAluCtrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: bypass vector table, hand-built hazard/stall/reset
// sequences, and randomized traffic against an instruction-level model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        idValid;
    logic [31:0] idRsData, idRtData, idImm;
    logic [4:0]  idRs, idRt, idRd;
    logic [1:0]  idAluCtrl;
    logic        idAluSrcImm, idRegWrite, idMemRead, idMemWrite;
    logic        memFwdEn, wbFwdEn;
    logic [4:0]  memFwdReg, wbFwdReg;
    logic [31:0] memFwdData, wbFwdData;
    logic [31:0] aluSrcA, aluSrcB, exStoreData;
    logic [1:0]  ctrl;
    logic        exValid, exRegWrite, exMemRead, exMemWrite, loadUseHazard;
    logic [4:0]  exRd;
    logic [1:0]  bubbleCount;

    int nCompared = 0;
    int nMismatch = 0;

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .idValid(idValid), .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm),
        .idRs(idRs), .idRt(idRt), .idRd(idRd), .idAluCtrl(idAluCtrl),
        .idAluSrcImm(idAluSrcImm), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
        .idMemWrite(idMemWrite),
        .memFwdEn(memFwdEn), .memFwdReg(memFwdReg), .memFwdData(memFwdData),
        .wbFwdEn(wbFwdEn), .wbFwdReg(wbFwdReg), .wbFwdData(wbFwdData),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ctrl(ctrl),
        .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMemWrite(exMemWrite), .exRd(exRd), .exStoreData(exStoreData),
        .loadUseHazard(loadUseHazard), .bubbleCount(bubbleCount)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // model of the instruction sitting in EX
    logic        mValid, mRegWrite, mMemRead, mMemWrite, mSrcImm, mKnown;
    logic [31:0] mRsData, mRtData, mImm;
    logic [4:0]  mRs, mRt, mRd;
    logic [1:0]  mCtrl;
    int          mCnt;

    function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] dflt);
        if (r == 5'd0) return dflt;
        if (memFwdEn && memFwdReg == r) return memFwdData;
        if (wbFwdEn && wbFwdReg == r) return wbFwdData;
        return dflt;
    endfunction

    function automatic logic modelHazard();
        return mValid && mMemRead && mRd != 5'd0 && idValid && (idRs == mRd || idRt == mRd);
    endfunction

    task automatic modelEdge();
        logic haz;
        haz = modelHazard();
        if (rst) begin
            {mValid, mRegWrite, mMemRead, mMemWrite, mSrcImm} = '0;
            {mRsData, mRtData, mImm, mRs, mRt, mRd, mCtrl} = '0;
            mKnown = 1'b1;
            mCnt = 0;
        end else if (flush || (!stall && haz)) begin
            {mValid, mRegWrite, mMemRead, mMemWrite} = '0;
            mKnown = 1'b0;
            if (!flush && mCnt < 3) mCnt++;
        end else if (!stall) begin
            mValid = idValid;   mRegWrite = idRegWrite & idValid;
            mMemRead = idMemRead & idValid; mMemWrite = idMemWrite & idValid;
            mRsData = idRsData; mRtData = idRtData; mImm = idImm;
            mRs = idRs; mRt = idRt; mRd = idRd; mCtrl = idAluCtrl; mSrcImm = idAluSrcImm;
            mKnown = 1'b1;
        end
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        logic [31:0] expB;
        chk("exValid", 32'(exValid), 32'(mValid));
        chk("exRegWrite", 32'(exRegWrite), 32'(mRegWrite));
        chk("exMemRead", 32'(exMemRead), 32'(mMemRead));
        chk("exMemWrite", 32'(exMemWrite), 32'(mMemWrite));
        chk("loadUseHazard", 32'(loadUseHazard), 32'(modelHazard()));
        chk("bubbleCount", 32'(bubbleCount), 32'(mCnt));
        if (mKnown) begin
            expB = mSrcImm ? mImm : bypass(mRt, mRtData);
            chk("aluSrcA", aluSrcA, bypass(mRs, mRsData));
            chk("aluSrcB", aluSrcB, expB);
            chk("exStoreData", exStoreData, bypass(mRt, mRtData));
            chk("ctrl", 32'(ctrl), 32'(mCtrl));
            chk("exRd", 32'(exRd), 32'(mRd));
        end
    endtask

    // driver tasks: inputs change just after the falling edge
    task automatic step();
        #1 checkModel();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic clearIn();
        {rst, stall, flush, idValid, idAluSrcImm, idRegWrite, idMemRead, idMemWrite} = '0;
        {idRsData, idRtData, idImm, idRs, idRt, idRd, idAluCtrl} = '0;
        {memFwdEn, wbFwdEn, memFwdReg, wbFwdReg, memFwdData, wbFwdData} = '0;
    endtask

    task automatic setInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic rd_mem, input logic wr_reg);
        idValid = 1'b1; idRs = rs; idRt = rt; idRd = rd;
        idMemRead = rd_mem; idRegWrite = wr_reg; idMemWrite = 1'b0;
        idRsData = 32'h100 + 32'(rs); idRtData = 32'h200 + 32'(rt);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] rsData, rtData, imm;
        logic        srcImm;
        logic [1:0]  aluCtrl;
        logic        memEn;
        logic [4:0]  memReg;
        logic [31:0] memData;
        logic        wbEn;
        logic [4:0]  wbReg;
        logic [31:0] wbData;
        logic [31:0] expA, expB, expStore;
        logic [1:0]  expCtrl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 2'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                    32'd5, 32'd7, 32'd7, 2'd2};
        vecs[1] = '{5'd3, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 2'd1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
                    32'hAA, 32'h22, 32'h22, 2'd1};
        vecs[2] = '{5'd3, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 2'd1, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
                    32'hBB, 32'h22, 32'h22, 2'd1};
        vecs[3] = '{5'd0, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 2'd0, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB,
                    32'h11, 32'h22, 32'h22, 2'd0};
        vecs[4] = '{5'd3, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 2'd3, 1'b1, 5'd6, 32'hCC, 1'b1, 5'd6, 32'hDD,
                    32'h11, 32'hCC, 32'hCC, 2'd3};
        vecs[5] = '{5'd3, 5'd6, 32'h11, 32'h22, 32'hFFFF_FFF0, 1'b1, 2'd0, 1'b1, 5'd6, 32'hCC, 1'b0, 5'd0, 32'd0,
                    32'h11, 32'hFFFF_FFF0, 32'hCC, 2'd0};
        vecs[6] = '{5'd3, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 2'd2, 1'b1, 5'd7, 32'hCC, 1'b1, 5'd6, 32'hDD,
                    32'h11, 32'hDD, 32'hDD, 2'd2};
        vecs[7] = '{5'd6, 5'd0, 32'h11, 32'h22, 32'd0, 1'b0, 2'd1, 1'b0, 5'd6, 32'hCC, 1'b1, 5'd0, 32'hDD,
                    32'h11, 32'h22, 32'h22, 2'd1};

        clearIn();
        mKnown = 1'b0; mValid = 1'b0; mMemRead = 1'b0; mRd = 5'd0; mCnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst aluSrcA", aluSrcA, 32'd0);
        chk("rst aluSrcB", aluSrcB, 32'd0);
        chk("rst ctrl", 32'(ctrl), 32'd0);
        chk("rst exValid", 32'(exValid), 32'd0);
        chk("rst ctlbits", 32'({exRegWrite, exMemRead, exMemWrite}), 32'd0);
        chk("rst hazard", 32'(loadUseHazard), 32'd0);
        chk("rst bubbleCount", 32'(bubbleCount), 32'd0);

        // bypass table: load each instruction, then drive the bypass buses
        for (int i = 0; i < 8; i++) begin
            clearIn();
            idValid = 1'b1; idRegWrite = 1'b1;
            idRs = vecs[i].rs; idRt = vecs[i].rt; idRsData = vecs[i].rsData; idRtData = vecs[i].rtData;
            idImm = vecs[i].imm; idAluSrcImm = vecs[i].srcImm; idAluCtrl = vecs[i].aluCtrl;
            step();
            memFwdEn = vecs[i].memEn; memFwdReg = vecs[i].memReg; memFwdData = vecs[i].memData;
            wbFwdEn = vecs[i].wbEn; wbFwdReg = vecs[i].wbReg; wbFwdData = vecs[i].wbData;
            #1;
            chk($sformatf("vec%0d aluSrcA", i), aluSrcA, vecs[i].expA);
            chk($sformatf("vec%0d aluSrcB", i), aluSrcB, vecs[i].expB);
            chk($sformatf("vec%0d exStoreData", i), exStoreData, vecs[i].expStore);
            chk($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].expCtrl));
            chk($sformatf("vec%0d exValid", i), 32'(exValid), 32'd1);
            step();
        end

        // load-use bubble
        clearIn(); doReset();
        setInstr(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        step();
        setInstr(5'd4, 5'd9, 5'd5, 1'b0, 1'b1);
        #1 chk("lu hazard", 32'(loadUseHazard), 32'd1);
        step();
        chk("lu exValid", 32'(exValid), 32'd0);
        chk("lu bubbleCount", 32'(bubbleCount), 32'd1);
        step();
        chk("lu reissue exValid", 32'(exValid), 32'd1);

        // load to r0 never creates a hazard
        setInstr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
        step();
        setInstr(5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
        #1 chk("r0 no hazard", 32'(loadUseHazard), 32'd0);
        step();

        // flush together with a hazard counts as flush
        setInstr(5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        step();
        setInstr(5'd7, 5'd2, 5'd5, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush+haz count", 32'(bubbleCount), 32'd1);
        chk("flush+haz exValid", 32'(exValid), 32'd0);

        // stall holds EX, then stall with flush empties it
        clearIn();
        idValid = 1'b1; idRegWrite = 1'b1; idRs = 5'd1; idRt = 5'd2; idRd = 5'd9;
        idRsData = 32'h1234; idRtData = 32'h5678; idAluCtrl = 2'd1;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idRsData = $urandom; idRtData = $urandom; idRd = 5'($urandom_range(0, 31));
            idAluCtrl = 2'($urandom_range(0, 3));
            step();
            chk("stall aluSrcA", aluSrcA, 32'h1234);
            chk("stall aluSrcB", aluSrcB, 32'h5678);
            chk("stall exRd", 32'(exRd), 32'd9);
            chk("stall ctrl", 32'(ctrl), 32'd1);
            chk("stall exValid", 32'(exValid), 32'd1);
        end
        flush = 1'b1;
        step();
        chk("stallflush exValid", 32'(exValid), 32'd0);
        chk("stallflush exRegWrite", 32'(exRegWrite), 32'd0);

        // saturation: five hazard bubbles on a 2-bit counter
        clearIn(); doReset();
        for (int i = 0; i < 5; i++) begin
            setInstr(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
            step();
            setInstr(5'd3, 5'd4, 5'd5, 1'b0, 1'b1);
            step();
        end
        chk("sat bubbleCount", 32'(bubbleCount), 32'd3);

        // reset while a hazard is pending, then a normal load
        setInstr(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        step();
        setInstr(5'd4, 5'd2, 5'd5, 1'b0, 1'b1);
        stall = 1'b1;
        #1 chk("pre-rst hazard", 32'(loadUseHazard), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("mid rst aluSrcA", aluSrcA, 32'd0);
        chk("mid rst aluSrcB", aluSrcB, 32'd0);
        chk("mid rst exValid", 32'(exValid), 32'd0);
        chk("mid rst bubbleCount", 32'(bubbleCount), 32'd0);
        chk("mid rst hazard", 32'(loadUseHazard), 32'd0);
        step();
        chk("post rst load", 32'(exValid), 32'd1);
        chk("post rst aluSrcA", aluSrcA, 32'h104);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            idValid = ($urandom_range(0, 5) != 0);
            idRs = 5'($urandom_range(0, 7)); idRt = 5'($urandom_range(0, 7));
            idRd = 5'($urandom_range(0, 7));
            idRsData = $urandom; idRtData = $urandom; idImm = $urandom;
            idAluCtrl = 2'($urandom_range(0, 3)); idAluSrcImm = 1'($urandom_range(0, 1));
            idRegWrite = 1'($urandom_range(0, 1)); idMemWrite = 1'($urandom_range(0, 1));
            idMemRead = ($urandom_range(0, 2) == 0);
            memFwdEn = 1'($urandom_range(0, 1)); memFwdReg = 5'($urandom_range(0, 7));
            memFwdData = $urandom;
            wbFwdEn = 1'($urandom_range(0, 1)); wbFwdReg = 5'($urandom_range(0, 7));
            wbFwdData = $urandom;
            step();
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
